// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, stereo pair type and drop counter width
package audio_pkg;
  localparam int AUDIO_DATA_SIZE = 24;
  localparam int DROP_CNT_W = 16;
  typedef struct packed {
    logic signed [23:0] left;
    logic signed [23:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/audio_out_fifo_sync_fifo.sv
// sync_fifo: generic flop FIFO with combinational head read and push-on-full-with-pop
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && (!full || pop);
  assign pop_ok = pop && !empty;
  assign rdata = mem[rd_ptr];
  // storage is deliberately not reset; occupancy tracking makes stale entries invisible
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;
  // pointers wrap naturally modulo DEPTH; count moves only on unbalanced push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/audio_out_fifo.sv
// audio_out_fifo: stereo FIFO draining to split left/right valid/ready channels; optional AUDIO_OUT_DROP_CNT_EN adds drop_count
module audio_out_fifo import audio_pkg::*; #(
  parameter int DATA_SIZE = AUDIO_DATA_SIZE,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_SIZE-1:0]   in_left,
  input  logic [DATA_SIZE-1:0]   in_right,
  input  logic                   in_ready,
  output logic [DATA_SIZE-1:0]   left_data,
  output logic                   left_valid,
  input  logic                   left_ready,
  output logic [DATA_SIZE-1:0]   right_data,
  output logic                   right_valid,
  input  logic                   right_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
`ifdef AUDIO_OUT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_count
`endif
);
  logic [2*DATA_SIZE-1:0] head;
  logic full, empty, l_sent, r_sent, l_hs, r_hs, pop, drop;
  sync_fifo #(.WIDTH(2*DATA_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_ready),
    .pop(pop),
    .wdata({in_left, in_right}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign left_valid = !empty && !l_sent;
  assign right_valid = !empty && !r_sent;
  assign left_data = empty ? '0 : head[2*DATA_SIZE-1:DATA_SIZE];
  assign right_data = empty ? '0 : head[DATA_SIZE-1:0];
  assign l_hs = left_valid && left_ready;
  assign r_hs = right_valid && right_ready;
  assign pop = (l_sent || l_hs) && (r_sent || r_hs);
  assign drop = in_ready && full && !pop;
  // each channel remembers it already delivered the head until the other side catches up
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      l_sent <= 1'b0;
      r_sent <= 1'b0;
    end else begin
      l_sent <= pop ? 1'b0 : l_sent || l_hs;
      r_sent <= pop ? 1'b0 : r_sent || r_hs;
    end
  // sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overflow <= 1'b0;
    else overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
`ifdef AUDIO_OUT_DROP_CNT_EN
  // saturating drop counter; a drop coinciding with a clear counts as the first new drop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_count <= '0;
    else if (clr_overflow) drop_count <= DROP_CNT_W'(drop);
    else if (drop && drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
`endif
endmodule

// File: tb/tb_audio_out_fifo.sv
// tb_audio_out_fifo: directed self-checking bench for audio_out_fifo
module tb_audio_out_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] in_left = '0, in_right = '0;
  logic in_ready = 1'b0, left_ready = 1'b0, right_ready = 1'b0, clr_overflow = 1'b0;
  logic [23:0] left_data, right_data;
  logic left_valid, right_valid, overflow;
  logic [3:0] count;
`ifdef AUDIO_OUT_DROP_CNT_EN
  logic [15:0] drop_count;
`endif
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  audio_out_fifo dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_left(in_left),
    .in_right(in_right),
    .in_ready(in_ready),
    .left_data(left_data),
    .left_valid(left_valid),
    .left_ready(left_ready),
    .right_data(right_data),
    .right_valid(right_valid),
    .right_ready(right_ready),
    .count(count),
    .overflow(overflow),
    .clr_overflow(clr_overflow)
`ifdef AUDIO_OUT_DROP_CNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [23:0] l, input logic [23:0] r);
    check({tag, "_lv"}, 32'(left_valid), 32'd1);
    check({tag, "_rv"}, 32'(right_valid), 32'd1);
    check({tag, "_ld"}, 32'(left_data), 32'(l));
    check({tag, "_rd"}, 32'(right_data), 32'(r));
  endtask

  initial begin
    tick;
    tick;
    check("rst_count", 32'(count), 32'd0);
    check("rst_lv", 32'(left_valid), 32'd0);
    check("rst_rv", 32'(right_valid), 32'd0);
    check("rst_ld", 32'(left_data), 32'd0);
    check("rst_rd", 32'(right_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
`ifdef AUDIO_OUT_DROP_CNT_EN
    check("rst_drop", 32'(drop_count), 32'd0);
`endif
    rst_n = 1'b1;
    // single pair through with both readies high
    left_ready = 1'b1;
    right_ready = 1'b1;
    in_left = 24'h000100;
    in_right = 24'hFFFF00;
    in_ready = 1'b1;
    tick;
    in_ready = 1'b0;
    head("t1", 24'h000100, 24'hFFFF00);
    check("t1_count1", 32'(count), 32'd1);
    tick;
    check("t1_count0", 32'(count), 32'd0);
    check("t1_lv0", 32'(left_valid), 32'd0);
    check("t1_ld0", 32'(left_data), 32'd0);
    // left ready, right stalled
    right_ready = 1'b0;
    in_left = 24'h10;
    in_right = 24'h20;
    in_ready = 1'b1;
    tick;
    head("t2_p0", 24'h10, 24'h20);
    in_left = 24'h11;
    in_right = 24'h21;
    tick;
    check("t2_lv_sent", 32'(left_valid), 32'd0);
    in_left = 24'h12;
    in_right = 24'h22;
    tick;
    in_ready = 1'b0;
    check("t2_count3", 32'(count), 32'd3);
    check("t2_lv_hold", 32'(left_valid), 32'd0);
    check("t2_rv", 32'(right_valid), 32'd1);
    check("t2_rd0", 32'(right_data), 32'h20);
    check("t2_ld0", 32'(left_data), 32'h10);
    right_ready = 1'b1;
    tick;
    head("t2_p1", 24'h11, 24'h21);
    check("t2_count2", 32'(count), 32'd2);
    tick;
    head("t2_p2", 24'h12, 24'h22);
    tick;
    check("t2_count0", 32'(count), 32'd0);
    check("t2_rv0", 32'(right_valid), 32'd0);
    // overflow: nine pushes into depth eight
    left_ready = 1'b0;
    right_ready = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_left = 24'h100 + 24'(k);
      in_right = 24'h200 + 24'(k);
      tick;
      if (k == 7) check("t3_ovf_before", 32'(overflow), 32'd0);
    end
    in_ready = 1'b0;
    check("t3_count8", 32'(count), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
`ifdef AUDIO_OUT_DROP_CNT_EN
    check("t3_drop", 32'(drop_count), 32'd1);
`endif
    left_ready = 1'b1;
    right_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      head($sformatf("t3_d%0d", k), 24'h100 + 24'(k), 24'h200 + 24'(k));
      tick;
    end
    check("t3_count0", 32'(count), 32'd0);
    check("t3_lv0", 32'(left_valid), 32'd0);
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
`ifdef AUDIO_OUT_DROP_CNT_EN
    check("t3_drop_clr", 32'(drop_count), 32'd0);
`endif
    // push while full with a simultaneous pop
    left_ready = 1'b0;
    right_ready = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_left = 24'h300 + 24'(k);
      in_right = 24'h380 + 24'(k);
      tick;
    end
    check("t4_full", 32'(count), 32'd8);
    left_ready = 1'b1;
    right_ready = 1'b1;
    in_left = 24'h3AA;
    in_right = 24'h3BB;
    tick;
    in_ready = 1'b0;
    check("t4_count8", 32'(count), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
    for (int k = 1; k < 8; k++) begin
      head($sformatf("t4_d%0d", k), 24'h300 + 24'(k), 24'h380 + 24'(k));
      tick;
    end
    head("t4_last", 24'h3AA, 24'h3BB);
    tick;
    check("t4_count0", 32'(count), 32'd0);
    // sustained one pair per cycle across pointer wrap
    in_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_left = 24'h400 + 24'(k);
      in_right = 24'h500 + 24'(k);
      tick;
      check($sformatf("t5_ld%0d", k), 32'(left_data), 32'h400 + 32'(k));
      check($sformatf("t5_rd%0d", k), 32'(right_data), 32'h500 + 32'(k));
      check($sformatf("t5_cnt%0d", k), 32'(count), 32'd1);
    end
    in_ready = 1'b0;
    tick;
    check("t5_count0", 32'(count), 32'd0);
    // asynchronous reset mid-drain
    left_ready = 1'b0;
    right_ready = 1'b0;
    in_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_left = 24'h600 + 24'(k);
      in_right = 24'h700 + 24'(k);
      tick;
    end
    in_ready = 1'b0;
    left_ready = 1'b1;
    right_ready = 1'b1;
    tick;
    check("t6_count5", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_lv_async", 32'(left_valid), 32'd0);
    check("t6_rv_async", 32'(right_valid), 32'd0);
    check("t6_count_async", 32'(count), 32'd0);
    check("t6_ld_async", 32'(left_data), 32'd0);
    tick;
    rst_n = 1'b1;
    in_left = 24'h55AA;
    in_right = 24'h66BB;
    in_ready = 1'b1;
    tick;
    in_ready = 1'b0;
    head("t6_post", 24'h55AA, 24'h66BB);
    check("t6_count1", 32'(count), 32'd1);
    tick;
    check("t6_count0", 32'(count), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_out_fifo.md
# audio_out_fifo

Stereo output stage directly downstream of the pitch shifter. Captures each `in_ready`-qualified left/right sample pair into a small stereo FIFO. Drains the FIFO to the audio codec interface as two independent valid/ready channels (left and right). Absorbs the mismatch between the shifter's burst-per-input-sample timing and the codec's ready timing, and reports overflow.

## Interface
Parameters:
- `DATA_SIZE`, 24: sample width in bits, two's complement.
- `DEPTH`, 8: FIFO depth in stereo pairs; power of two, ≥ 2.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: reset; **asynchronous, active-low**.
- `in_left` input DATA_SIZE: left sample from the pitch shifter.
- `in_right` input DATA_SIZE: right sample from the pitch shifter.
- `in_ready` input 1: single-cycle strobe; the pair on `in_left`/`in_right` is valid this cycle.
- `left_data` output DATA_SIZE: left sample to the codec.
- `left_valid` output 1: `left_data` is valid.
- `left_ready` input 1: codec accepts the left sample.
- `right_data`, `right_valid`, `right_ready`: same as the left channel, for the right channel.
- `count` output $clog2(DEPTH)+1: occupancy in stereo pairs, 0..DEPTH.
- `overflow` output 1: sticky; a pair was dropped because the FIFO was full.
- `clr_overflow` input 1: synchronous clear of `overflow` (and of `drop_count` when it is compiled in).

## Operation
- Storage is a flop array of DEPTH `{left, right}` pairs, with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH. `count` is a registered counter.
- **Push:** when `in_ready` is high and the push is accepted, write the pair at `wr_ptr`, then increment `wr_ptr`.
- **Head data:** `left_data`/`right_data` are a combinational read of the entry at `rd_ptr`. They are 0 when the FIFO is empty.
- **Per-channel sent flags `l_sent`, `r_sent`:**
  - `left_valid = (count != 0) && !l_sent`; `right_valid` is the same with `r_sent`.
  - A left handshake (`left_valid && left_ready`) sets `l_sent`; a right handshake sets `r_sent`.
- **Pop:** a pop occurs in any cycle where `(l_sent || left handshake) && (r_sent || right handshake)`. On a pop:
  - increment `rd_ptr`;
  - clear both flags;
  - the next pair presents on the following cycle.
  
  Both channels may handshake in the same cycle and pop immediately.
- **Full:**
  - A push while `count == DEPTH` is accepted only if a pop occurs in the same cycle; `count` then stays at DEPTH.
  - Otherwise the pair is dropped, the FIFO is unchanged, and `overflow` sets on the next edge.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Empty:** a push into an empty FIFO raises both valids on the next cycle; no bypass path exists.
- **`clr_overflow` together with a drop in the same cycle:** the drop wins and `overflow` stays 1.
- **`rst_n` low at any time:**
  - pointers, `count`, flags and `overflow` clear immediately;
  - FIFO contents are discarded (the array itself is not reset);
  - valids drop to 0 asynchronously.

## Timing
- Reset values: `left_valid`=0, `right_valid`=0, `left_data`=0, `right_data`=0, `count`=0, `overflow`=0, `drop_count`=0.
- Latency: `in_ready` at edge N → `count` updated and valids high in cycle N+1.
- Minimum time for a pair to pass through: 1 cycle when both readies are held high.
- Sustained throughput: 1 pair per cycle.
- The valid/ready rules hold per channel. Once a channel's valid is asserted, it and its data stay stable until that channel's handshake.

## Configuration
- `AUDIO_OUT_DROP_CNT_EN` defined:
  - adds output port `drop_count` (16 bits);
  - it increments on every dropped pair and saturates at 16'hFFFF;
  - it clears on `clr_overflow` or reset.
- Not defined: no `drop_count` port, no counter logic; `overflow` alone reports drops.

## Structure
- Shared package `audio_pkg`:
  - `AUDIO_DATA_SIZE` = 24;
  - typedef `stereo_sample_t`, a packed struct `{logic signed [23:0] left; logic signed [23:0] right;}`;
  - `DROP_CNT_W` = 16.
- One sub-module, `sync_fifo`: a generic width/depth flop FIFO with push/pop/full/empty/count.
- `audio_out_fifo` itself holds the split-channel handshake, the sent flags, and the overflow/drop logic.

## Test plan
- After reset, push (0x000100, 0xFFFF00) with both readies high → both valids high next cycle with those values; `count` goes 1→0 one cycle later.
- Push 3 pairs with `left_ready`=1 and `right_ready`=0 → the left channel emits only pair 0, then `left_valid`=0; raising `right_ready` drains the pairs in order 0, 1, 2 on both channels.
- Push 9 pairs with both readies low (DEPTH=8) → `count`=8, `overflow`=1, pair 9 is absent on drain, and `drop_count`=1 when `AUDIO_OUT_DROP_CNT_EN` is defined.
- At `count`=8, push with both readies high in the same cycle → the push is accepted, `count` stays 8, `overflow` stays 0.
- Push 20 pairs with both readies high → pointer wrap-around preserves order; `count` returns to 0.
- Assert `rst_n` low mid-drain at `count`=5 → valids drop immediately and `count`=0. After release, a single push is emitted intact.
